// File: rtl/clken_rr_sched_if.sv
// Handshake bundle between the clock-enable tick source, the switches and the
// per-channel consumers of clken_rr_sched.
interface clken_rr_sched_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int ID_W   = $clog2(NUM_CH)
);
  logic                    i_tick;
  logic [NUM_CH-1:0]       i_sw;
  logic                    i_clr;
  logic [NUM_CH-1:0]       o_run;
  logic [NUM_CH-1:0]       o_en;
  logic [ID_W-1:0]         o_grant_id;
  logic [NUM_CH*CNT_W-1:0] o_cnt;
  logic                    o_busy;

  modport master (output i_tick, i_sw, i_clr,
                  input  o_run, o_en, o_grant_id, o_cnt, o_busy);
  modport slave  (input  i_tick, i_sw, i_clr,
                  output o_run, o_en, o_grant_id, o_cnt, o_busy);
endinterface

// File: rtl/clken_rr_sched.sv
// Round-robin sharing of a clock-enable tick among switch-toggled counter
// channels; one lane instance per channel holds run flag, enable and counter.
module clken_rr_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             run_d_i,
  input  logic             gnt_i,
  output logic             run_o,
  output logic             en_o,
  output logic [CNT_W-1:0] cnt_o
);
  logic             run_q, en_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      en_q  <= 1'b0;
      cnt_q <= '0;
    end else if (clr_i) begin
      run_q <= 1'b0;
      en_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      run_q <= run_d_i;
      en_q  <= gnt_i;
      if (gnt_i) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign run_o = run_q;
  assign en_o  = en_q;
  assign cnt_o = cnt_q;
endmodule

module clken_rr_sched #(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 8,
  localparam int ID_W   = $clog2(NUM_CH)
) (
  input logic              clk,
  input logic              rst_n,
  clken_rr_sched_if.slave  bus
);
  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e                        state_q, state_d;
  logic [NUM_CH-1:0]             sw_prev_q, sw_rise, run_q, run_d, gnt_d, en_q;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt_q;
  logic [ID_W-1:0]               ptr_q, ptr_d, gid_q, gid_d;

  assign sw_rise = bus.i_sw & ~sw_prev_q;
  assign run_d   = run_q ^ sw_rise;

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_lane
      clken_rr_lane #(.CNT_W(CNT_W)) u_lane (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (bus.i_clr),
        .run_d_i (run_d[k]),
        .gnt_i   (gnt_d[k]),
        .run_o   (run_q[k]),
        .en_o    (en_q[k]),
        .cnt_o   (cnt_q[k])
      );
    end
  endgenerate

  // Search order starts just after the last grant; arbitration sees the
  // registered run flags, so a same-cycle toggle cannot steal the tick.
  always_comb begin
    int idx;
    logic found;
    gnt_d = '0;
    ptr_d = ptr_q;
    gid_d = gid_q;
    found = 1'b0;
    idx   = 0;
    if (state_q == ACTIVE && bus.i_tick && !bus.i_clr) begin
      for (int i = 1; i <= NUM_CH; i++) begin
        idx = (int'(ptr_q) + i) % NUM_CH;
        if (!found && run_q[idx]) begin
          found      = 1'b1;
          gnt_d[idx] = 1'b1;
          ptr_d      = ID_W'(idx);
          gid_d      = ID_W'(idx);
        end
      end
    end
    if (bus.i_clr) ptr_d = ID_W'(NUM_CH - 1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!bus.i_clr && |run_d)  state_d = ACTIVE;
      ACTIVE:  if (bus.i_clr || !(|run_d)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sw_prev_q <= '0;
      ptr_q     <= ID_W'(NUM_CH - 1);
      gid_q     <= ID_W'(NUM_CH - 1);
    end else begin
      state_q   <= state_d;
      sw_prev_q <= bus.i_sw;
      ptr_q     <= ptr_d;
      gid_q     <= gid_d;
    end
  end

  assign bus.o_run      = run_q;
  assign bus.o_en       = en_q;
  assign bus.o_cnt      = cnt_q;
  assign bus.o_grant_id = gid_q;
  assign bus.o_busy     = (state_q == ACTIVE);
endmodule

// File: tb/tb_clken_rr_sched.sv
// Randomized and directed checks of clken_rr_sched against a rule-level
// model of run flags, round-robin grants and wrapping counters.
module tb_clken_rr_sched;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clken_rr_sched_if #(.NUM_CH(N), .CNT_W(W)) bus ();
  clken_rr_sched #(.NUM_CH(N), .CNT_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  bit m_run [N];
  bit m_prev[N];
  bit m_en  [N];
  int m_cnt [N];
  int m_ptr, m_gid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_run[k] = 0; m_prev[k] = 0; m_en[k] = 0; m_cnt[k] = 0;
    end
    m_ptr = N - 1;
    m_gid = N - 1;
  endtask

  function automatic bit any_run();
    bit a = 0;
    for (int k = 0; k < N; k++) a |= m_run[k];
    return a;
  endfunction

  task automatic model_clock(input bit tk, input logic [N-1:0] sw, input bit clr);
    for (int k = 0; k < N; k++) m_en[k] = 0;
    if (clr) begin
      for (int k = 0; k < N; k++) begin m_run[k] = 0; m_cnt[k] = 0; end
      m_ptr = N - 1;
    end else begin
      if (tk && any_run()) begin
        for (int j = 1; j <= N; j++) begin
          int c = (m_ptr + j) % N;
          if (m_run[c]) begin
            m_en[c]  = 1;
            m_cnt[c] = (m_cnt[c] + 1) % (1 << W);
            m_ptr    = c;
            m_gid    = c;
            break;
          end
        end
      end
      for (int k = 0; k < N; k++) if (sw[k] && !m_prev[k]) m_run[k] = !m_run[k];
    end
    for (int k = 0; k < N; k++) m_prev[k] = sw[k];
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0]   er, ee;
    logic [N*W-1:0] ec;
    for (int k = 0; k < N; k++) begin
      er[k] = m_run[k];
      ee[k] = m_en[k];
      ec[k*W +: W] = W'(m_cnt[k]);
    end
    chk({tag, ".run"},  bus.o_run, er);
    chk({tag, ".en"},   bus.o_en,  ee);
    chk({tag, ".cnt"},  bus.o_cnt, ec);
    chk({tag, ".busy"}, bus.o_busy, any_run());
    chk({tag, ".gid"},  bus.o_grant_id, m_gid);
  endtask

  task automatic step(input string tag, input bit tk, input logic [N-1:0] sw, input bit clr);
    bus.i_tick = tk; bus.i_sw = sw; bus.i_clr = clr;
    @(posedge clk);
    model_clock(tk, sw, clr);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic pulse(input string tag, input logic [N-1:0] m);
    step(tag, 0, m, 0);
    step(tag, 0, '0, 0);
  endtask

  initial begin
    logic [N-1:0] swr;
    bus.i_tick = 0; bus.i_sw = '0; bus.i_clr = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // idle: ticks with no running channel
    for (int r = 0; r < 3; r++) begin
      step("idle", 1, '0, 0);
      repeat (9) step("idle", 0, '0, 0);
    end

    // single channel 2, five ticks
    pulse("single", 4'b0100);
    for (int t = 0; t < 5; t++) begin
      step("single", 1, '0, 0);
      step("single", 0, '0, 0);
    end
    chk("single_cnt2", bus.o_cnt, 32'h0005_0000);

    // fairness across 0,1,3
    step("rr_clr", 0, '0, 1);
    pulse("rr", 4'b1011);
    for (int t = 0; t < 6; t++) begin
      step("rr", 1, '0, 0);
      step("rr", 0, '0, 0);
    end
    chk("rr_cnt", bus.o_cnt, 32'h0200_0202);
    chk("rr_gid", bus.o_grant_id, 3);

    // wrap with back-to-back ticks on channel 1
    step("wrap_clr", 0, '0, 1);
    pulse("wrap", 4'b0010);
    repeat (257) step("wrap", 1, '0, 0);
    chk("wrap_cnt1", bus.o_cnt[15:8], 8'd1);
    step("wrap", 0, '0, 0);

    // toggle and tick in the same cycle
    step("tog_clr", 0, '0, 1);
    pulse("tog", 4'b0001);
    step("tog", 1, 4'b0001, 0);
    chk("tog_en0", bus.o_en, 4'b0001);
    step("tog", 1, '0, 0);
    chk("tog_busy", bus.o_busy, 1'b0);
    step("tog", 0, '0, 0);

    // clear priority: ch2=9, ch1=7 then clear with tick and sw3 edge
    step("clr_clr", 0, '0, 1);
    pulse("clr", 4'b0100);
    repeat (2) step("clr", 1, '0, 0);
    pulse("clr", 4'b0010);
    repeat (14) step("clr", 1, '0, 0);
    chk("clr_pre_cnt", bus.o_cnt, 32'h0009_0700);
    step("clr", 1, 4'b1000, 1);
    chk("clr_cnt0", bus.o_cnt, 32'h0);
    pulse("clr", 4'b0101);
    step("clr", 1, '0, 0);
    chk("clr_first_gid", bus.o_grant_id, 0);

    // randomized traffic
    swr = '0;
    for (int t = 0; t < 2000; t++) begin
      for (int k = 0; k < N; k++) if ($urandom_range(0, 7) == 0) swr[k] = ~swr[k];
      step("rand", 1'($urandom_range(0, 1)), swr, $urandom_range(0, 63) == 0);
    end

    // async reset while an enable is high
    step("arst_clr", 0, '0, 1);
    pulse("arst", 4'b0010);
    bus.i_tick = 1;
    @(posedge clk);
    model_clock(1, '0, 0);
    #2;
    chk("arst_pre_en", bus.o_en, 4'b0010);
    rst_n = 1'b0;
    #1;
    chk("arst_en",   bus.o_en, 4'b0000);
    chk("arst_cnt",  bus.o_cnt, 32'h0);
    chk("arst_busy", bus.o_busy, 1'b0);
    chk("arst_gid",  bus.o_grant_id, N - 1);
    model_reset();
    bus.i_tick = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step("post_arst", 1, '0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
